// File: rtl/serial_add_sub.sv
//----------------------------------------------------------------------------
// Module      : serial_add_sub
// Description : Bit-serial two's-complement adder/subtractor, LSB first,
//               one full-adder cell, start/done handshake.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic             sub_q;
  logic [CW-1:0]    cnt;
  logic             sum_bit;
  logic             carry_next;
  logic             last_bit;

  assign sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last_bit   = (state == S_RUN) && (cnt == LAST_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (cnt == LAST_BIT) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN) || (state == S_DONE);
    done = (state == S_DONE);
  end

  // Subtraction is a + ~b + 1: invert b on load and seed the carry with sub.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start) begin
        a_sh  <= a;
        b_sh  <= sub ? ~b : b;
        carry <= sub;
        sub_q <= sub;
        cnt   <= '0;
      end
    end else if (state == S_RUN) begin
      result <= {sum_bit, result[WIDTH-1:1]};
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= carry_next;
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        // A missing carry out of the MSB means a borrow in subtract mode.
        ovf  <= carry ^ carry_next;
        cout <= carry_next ^ sub_q;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sub.sv
//----------------------------------------------------------------------------
// Module      : tb_serial_add_sub
// Description : Scoreboard bench for serial_add_sub (WIDTH=8).
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_serial_add_sub;

  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [7:0] result;
  logic       cout;
  logic       ovf;
  logic       busy;
  logic       done;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  serial_add_sub #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .result(result), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic s, input logic [7:0] x, input logic [7:0] y);
    exp_t       m;
    logic [8:0] t;
    if (!s) begin
      t   = {1'b0, x} + {1'b0, y};
      m.r = t[7:0];
      m.c = t[8];
      m.o = (x[7] == y[7]) && (m.r[7] != x[7]);
    end else begin
      m.r = x - y;
      m.c = (x < y);
      m.o = (x[7] != y[7]) && (m.r[7] != x[7]);
    end
    return m;
  endfunction

  task automatic issue(input logic s, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    sub = s; a = x; b = y; start = 1'b1;
    sb.push_back(model(s, x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({result, cout, ovf, busy, done} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_in: got %h/%b/%b/%b/%b required 00/0/0/0/0", result, cout, ovf, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({result, cout, ovf, busy, done} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_idle: got %h/%b/%b/%b/%b required 00/0/0/0/0", result, cout, ovf, busy, done);
    end
  endtask

  task automatic test_latency;
    exp_t e;
    int   bcount;
    int   dcyc;
    issue(1'b1, 8'h35, 8'h12);
    bcount = busy ? 1 : 0;
    dcyc   = -1;
    e      = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (busy) bcount++;
      if (done && dcyc < 0) begin
        dcyc = i + 1;
        pop_exp(e);
        n_cmp++;
        if ({result, cout, ovf} !== e) begin
          n_bad++;
          $display("FAIL lat_result: got %h/%b/%b required %h/%b/%b", result, cout, ovf, e.r, e.c, e.o);
        end
      end
      if (!busy) break;
    end
    n_cmp++;
    if (dcyc != 8) begin
      n_bad++;
      $display("FAIL lat_done: got %0d cycles required 8", dcyc);
    end
    n_cmp++;
    if (bcount != 9) begin
      n_bad++;
      $display("FAIL lat_busy: got %0d cycles required 9", bcount);
    end
  endtask

  task automatic test_arith;
    logic       s_v[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] a_v[4] = '{8'h12, 8'h80, 8'hFF, 8'h7F};
    logic [7:0] b_v[4] = '{8'h35, 8'h01, 8'h01, 8'h01};
    exp_t       e;
    bit         ok;
    for (int i = 0; i < 4; i++) begin
      issue(s_v[i], a_v[i], b_v[i]);
      if (i == 2) begin
        // Previous op left cout=0, ovf=1; they must hold while running.
        @(posedge clk); #1;
        n_cmp++;
        if ({cout, ovf} !== 2'b01) begin
          n_bad++;
          $display("FAIL run_hold: got cout/ovf %b%b required 01", cout, ovf);
        end
      end
      wait_done(ok);
      pop_exp(e);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL arith_timeout[%0d]: got no done required done", i);
      end
      n_cmp++;
      if (result !== e.r) begin
        n_bad++;
        $display("FAIL arith_result[%0d]: got %h required %h", i, result, e.r);
      end
      n_cmp++;
      if (cout !== e.c) begin
        n_bad++;
        $display("FAIL arith_cout[%0d]: got %b required %b", i, cout, e.c);
      end
      n_cmp++;
      if (ovf !== e.o) begin
        n_bad++;
        $display("FAIL arith_ovf[%0d]: got %b required %b", i, ovf, e.o);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bit   ok;
    @(negedge clk);
    sub = 1'b0; a = 8'h10; b = 8'h01; start = 1'b1;
    sb.push_back(model(1'b0, 8'h10, 8'h01));
    @(negedge clk);
    a = 8'hAA; b = 8'h55;
    sb.push_back(model(1'b0, 8'hAA, 8'h55));
    wait_done(ok);
    pop_exp(e);
    n_cmp++;
    if (!ok || {result, cout, ovf} !== e) begin
      n_bad++;
      $display("FAIL b2b_first: got %b %h/%b/%b required 1 %h/%b/%b", ok, result, cout, ovf, e.r, e.c, e.o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_bad++;
      $display("FAIL b2b_single_done: got busy/done %b%b required 00", busy, done);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_restart: got busy %b required 1", busy);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    pop_exp(e);
    n_cmp++;
    if (!ok || {result, cout, ovf} !== e) begin
      n_bad++;
      $display("FAIL b2b_second: got %b %h/%b/%b required 1 %h/%b/%b", ok, result, cout, ovf, e.r, e.c, e.o);
    end
    @(posedge clk);
  endtask

  task automatic test_abort;
    exp_t e;
    bit   ok;
    int   dcount;
    issue(1'b0, 8'h3C, 8'h0F);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({result, cout, ovf, busy, done} !== 12'h000) begin
      n_bad++;
      $display("FAIL abort_outputs: got %h/%b/%b/%b/%b required 00/0/0/0/0", result, cout, ovf, busy, done);
    end
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    n_cmp++;
    if (dcount != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_nodone: got %0d dones busy %b required 0 dones busy 0", dcount, busy);
    end
    issue(1'b0, 8'h3C, 8'h0F);
    wait_done(ok);
    pop_exp(e);
    n_cmp++;
    if (!ok || {result, cout, ovf} !== e) begin
      n_bad++;
      $display("FAIL abort_fresh: got %b %h/%b/%b required 1 %h/%b/%b", ok, result, cout, ovf, e.r, e.c, e.o);
    end
    @(posedge clk);
  endtask

  task automatic test_sweep;
    logic [7:0] cv[9] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF, 8'h55, 8'hAA};
    logic [7:0] x;
    logic [7:0] y;
    logic       s;
    exp_t       e;
    bit         ok;
    for (int k = 0; k < 162 + 600; k++) begin
      if (k < 162) begin
        s = k[0];
        x = cv[(k / 2) % 9];
        y = cv[(k / 18) % 9];
      end else begin
        s = 1'($urandom_range(0, 1));
        x = 8'($urandom_range(0, 255));
        y = 8'($urandom_range(0, 255));
      end
      issue(s, x, y);
      wait_done(ok);
      pop_exp(e);
      n_cmp++;
      if (!ok || {result, cout, ovf} !== e) begin
        n_bad++;
        $display("FAIL sweep sub=%b a=%h b=%h: got %b %h/%b/%b required 1 %h/%b/%b",
                 s, x, y, ok, result, cout, ovf, e.r, e.c, e.o);
      end
      @(posedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_arith;
    test_back_to_back;
    test_abort;
    test_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
